fractal_frame_controller: RTL and testbench

Configuration sequencer in front of fractal_generator. Holds software-written shadow parameters and applies them atomically at frame boundaries. Pulses the generator reset when geometry changes. Optionally animates the Julia constant (cr, ci) by a per-frame increment. Counts pixels and lines on the generator's output stream to find frame boundaries.

---
 rtl/fractal_frame_controller.sv | 257 +++++++++++++++++++++++++
 tb/tb_fractal_frame_controller.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fractal_frame_controller.sv
// fractal_frame_controller
// Holds software-written shadow parameters for fractal_generator and applies
// them atomically at output frame boundaries. A geometry change re-runs the
// generator reset pulse; otherwise the Julia constant can be animated per frame.
// Frame boundaries are found by counting pixels and lines on the output stream.
module fractal_frame_controller #(
  parameter int DEF_WIDTH    = 640,
  parameter int DEF_HEIGHT   = 480,
  parameter int RESET_CYCLES = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cfg_wr_valid,
  output logic        cfg_wr_ready,
  input  logic [3:0]  cfg_wr_addr,
  input  logic [31:0] cfg_wr_data,
  input  logic        cfg_commit,
  input  logic        s_tvalid,
  input  logic        s_tuser,
  input  logic        s_tlast,
  output logic        gen_resetn,
  output logic [15:0] width_out,
  output logic [15:0] height_out,
  output logic [31:0] cr_out,
  output logic [31:0] ci_out,
  output logic [31:0] dx_out,
  output logic [31:0] dy_out,
  output logic [31:0] x0_out,
  output logic [31:0] y0_out,
  output logic        commit_pending,
  output logic [31:0] frame_count
);

  localparam int CNT_W = (RESET_CYCLES > 2) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);

  localparam logic [3:0] ADDR_GEOM = 4'd0;
  localparam logic [3:0] ADDR_CR   = 4'd1;
  localparam logic [3:0] ADDR_CI   = 4'd2;
  localparam logic [3:0] ADDR_DX   = 4'd3;
  localparam logic [3:0] ADDR_DY   = 4'd4;
  localparam logic [3:0] ADDR_X0   = 4'd5;
  localparam logic [3:0] ADDR_Y0   = 4'd6;
  localparam logic [3:0] ADDR_DCR  = 4'd7;
  localparam logic [3:0] ADDR_DCI  = 4'd8;
  localparam logic [3:0] ADDR_CTRL = 4'd9;

  typedef enum logic {
    ST_GEN_RST = 1'b0,
    ST_RUN     = 1'b1
  } state_t;

  // One full parameter set; shadow and active copies share this layout so a
  // commit is a single struct copy.
  typedef struct packed {
    logic [15:0] width;
    logic [15:0] height;
    logic [31:0] cr;
    logic [31:0] ci;
    logic [31:0] dx;
    logic [31:0] dy;
    logic [31:0] x0;
    logic [31:0] y0;
    logic [31:0] dcr;
    logic [31:0] dci;
    logic        anim;
  } param_t;

  localparam param_t PARAM_RST = '{
    width:  16'(DEF_WIDTH),
    height: 16'(DEF_HEIGHT),
    cr:     32'd0,
    ci:     32'd0,
    dx:     32'd0,
    dy:     32'd0,
    x0:     32'd0,
    y0:     32'd0,
    dcr:    32'd0,
    dci:    32'd0,
    anim:   1'b0
  };

  state_t           state_r, state_s;
  logic [CNT_W-1:0] rst_cnt_r, rst_cnt_s;
  logic [15:0]      pix_r, pix_s;
  logic [15:0]      line_r, line_s;
  logic             pending_r, pending_s;
  logic             ready_r, ready_s;
  logic             gen_r, gen_s;
  logic [31:0]      fc_r, fc_s;
  param_t           sh_r, sh_s;
  param_t           act_r, act_s;

  logic             wr_fire_s;
  logic             commit_ok_s;
  logic             sync_err_s;
  logic [15:0]      pix_eff_s;
  logic [15:0]      line_eff_s;
  logic             frame_end_s;
  logic             geom_change_s;

  // A write lands only while the handshake is open; a commit opens a pending window.
  assign wr_fire_s   = cfg_wr_valid && ready_r;
  assign commit_ok_s = cfg_commit && (state_r == ST_RUN) && !pending_r;

  // A frame_start beat away from line 0 pixel 0 abandons the current frame and
  // is taken as pixel 0 of a fresh one.
  assign sync_err_s    = (state_r == ST_RUN) && s_tvalid && s_tuser &&
                         ((pix_r != 16'd0) || (line_r != 16'd0));
  assign pix_eff_s     = sync_err_s ? 16'd0 : pix_r;
  assign line_eff_s    = sync_err_s ? 16'd0 : line_r;
  assign frame_end_s   = (state_r == ST_RUN) && s_tvalid && s_tlast &&
                         (line_eff_s == (act_r.height - 16'd1));
  assign geom_change_s = {sh_r.height, sh_r.width} != {act_r.height, act_r.width};

  // Next-state, stream counters, commit/apply/animate and shadow writes.
  always_comb begin
    state_s   = state_r;
    rst_cnt_s = rst_cnt_r;
    pix_s     = pix_r;
    line_s    = line_r;
    pending_s = pending_r;
    fc_s      = fc_r;
    gen_s     = gen_r;
    sh_s      = sh_r;
    act_s     = act_r;

    case (state_r)
      ST_GEN_RST: begin
        pix_s  = 16'd0;
        line_s = 16'd0;
        if (rst_cnt_r == RST_LAST) begin
          state_s   = ST_RUN;
          rst_cnt_s = CNT_W'(0);
          gen_s     = 1'b1;
        end else begin
          rst_cnt_s = rst_cnt_r + CNT_W'(1);
          gen_s     = 1'b0;
        end
      end
      ST_RUN: begin
        gen_s = 1'b1;
        if (s_tvalid) begin
          if (s_tlast) begin
            pix_s  = 16'd0;
            line_s = frame_end_s ? 16'd0 : (line_eff_s + 16'd1);
          end else begin
            pix_s  = pix_eff_s + 16'd1;
            line_s = line_eff_s;
          end
        end else begin
          pix_s  = pix_r;
        end
        if (commit_ok_s) begin
          pending_s = 1'b1;
        end else begin
          pending_s = pending_r;
        end
        if (frame_end_s) begin
          if (pending_r) begin
            act_s     = sh_r;
            pending_s = 1'b0;
            if (geom_change_s) begin
              fc_s      = 32'd0;
              state_s   = ST_GEN_RST;
              rst_cnt_s = CNT_W'(0);
              gen_s     = 1'b0;
              pix_s     = 16'd0;
              line_s    = 16'd0;
            end else begin
              fc_s = fc_r + 32'd1;
            end
          end else begin
            fc_s = fc_r + 32'd1;
            if (act_r.anim) begin
              act_s.cr = act_r.cr + act_r.dcr;
              act_s.ci = act_r.ci + act_r.dci;
            end else begin
              act_s = act_r;
            end
          end
        end else begin
          fc_s = fc_r;
        end
      end
      default: begin
        state_s   = ST_GEN_RST;
        rst_cnt_s = CNT_W'(0);
        gen_s     = 1'b0;
      end
    endcase

    if (wr_fire_s) begin
      case (cfg_wr_addr)
        ADDR_GEOM: begin
          sh_s.height = cfg_wr_data[31:16];
          sh_s.width  = cfg_wr_data[15:0];
        end
        ADDR_CR:   sh_s.cr   = cfg_wr_data;
        ADDR_CI:   sh_s.ci   = cfg_wr_data;
        ADDR_DX:   sh_s.dx   = cfg_wr_data;
        ADDR_DY:   sh_s.dy   = cfg_wr_data;
        ADDR_X0:   sh_s.x0   = cfg_wr_data;
        ADDR_Y0:   sh_s.y0   = cfg_wr_data;
        ADDR_DCR:  sh_s.dcr  = cfg_wr_data;
        ADDR_DCI:  sh_s.dci  = cfg_wr_data;
        ADDR_CTRL: sh_s.anim = cfg_wr_data[0];
        default:   sh_s      = sh_r;
      endcase
    end else begin
      sh_s = sh_r;
    end

    ready_s = (state_s == ST_RUN) && !pending_s;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r   <= ST_GEN_RST;
      rst_cnt_r <= CNT_W'(0);
      pix_r     <= 16'd0;
      line_r    <= 16'd0;
      pending_r <= 1'b0;
      ready_r   <= 1'b0;
      gen_r     <= 1'b0;
      fc_r      <= 32'd0;
      sh_r      <= PARAM_RST;
      act_r     <= PARAM_RST;
    end else begin
      state_r   <= state_s;
      rst_cnt_r <= rst_cnt_s;
      pix_r     <= pix_s;
      line_r    <= line_s;
      pending_r <= pending_s;
      ready_r   <= ready_s;
      gen_r     <= gen_s;
      fc_r      <= fc_s;
      sh_r      <= sh_s;
      act_r     <= act_s;
    end
  end

  assign cfg_wr_ready   = ready_r;
  assign gen_resetn     = gen_r;
  assign commit_pending = pending_r;
  assign frame_count    = fc_r;
  assign width_out      = act_r.width;
  assign height_out     = act_r.height;
  assign cr_out         = act_r.cr;
  assign ci_out         = act_r.ci;
  assign dx_out         = act_r.dx;
  assign dy_out         = act_r.dy;
  assign x0_out         = act_r.x0;
  assign y0_out         = act_r.y0;

endmodule

// File: tb/tb_fractal_frame_controller.sv
// Testbench for fractal_frame_controller: directed scenarios plus a randomized
// run, all checked against a register-map level reference model.
module tb_fractal_frame_controller;

  localparam int RC = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cfg_wr_valid;
  logic        cfg_wr_ready;
  logic [3:0]  cfg_wr_addr;
  logic [31:0] cfg_wr_data;
  logic        cfg_commit;
  logic        s_tvalid;
  logic        s_tuser;
  logic        s_tlast;
  logic        gen_resetn;
  logic [15:0] width_out;
  logic [15:0] height_out;
  logic [31:0] cr_out, ci_out, dx_out, dy_out, x0_out, y0_out;
  logic        commit_pending;
  logic [31:0] frame_count;

  int checks = 0;
  int errors = 0;

  fractal_frame_controller #(
    .DEF_WIDTH(640), .DEF_HEIGHT(480), .RESET_CYCLES(RC)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cfg_wr_valid(cfg_wr_valid), .cfg_wr_ready(cfg_wr_ready),
    .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data), .cfg_commit(cfg_commit),
    .s_tvalid(s_tvalid), .s_tuser(s_tuser), .s_tlast(s_tlast),
    .gen_resetn(gen_resetn), .width_out(width_out), .height_out(height_out),
    .cr_out(cr_out), .ci_out(ci_out), .dx_out(dx_out), .dy_out(dy_out),
    .x0_out(x0_out), .y0_out(y0_out),
    .commit_pending(commit_pending), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Reference model: register map as arrays. m_sh[0..9] = shadow registers
  // indexed by address; m_act[0..8] = active geometry and parameters.
  logic [31:0] m_sh [0:9];
  logic [31:0] m_act [0:8];
  logic        m_anim, m_pend, m_run;
  logic [31:0] m_fc;
  int          m_rst_left, m_line, m_pix;

  function automatic void model_step();
    bit rdy, acc, fe;
    int h;
    if (!resetn) begin
      for (int i = 0; i < 10; i++) m_sh[i] = 32'd0;
      for (int i = 0; i < 9; i++) m_act[i] = 32'd0;
      m_sh[0] = {16'd480, 16'd640};
      m_act[0] = {16'd480, 16'd640};
      m_anim = 1'b0; m_pend = 1'b0; m_fc = 32'd0; m_run = 1'b0;
      m_rst_left = RC; m_line = 0; m_pix = 0;
      return;
    end
    if (!m_run) begin
      m_rst_left--;
      if (m_rst_left == 0) m_run = 1'b1;
      m_line = 0; m_pix = 0;
      return;
    end
    rdy = !m_pend;
    acc = cfg_commit && !m_pend;
    fe = 1'b0;
    h = int'(m_act[0][31:16]);
    if (s_tvalid) begin
      if (s_tuser && (m_line != 0 || m_pix != 0)) begin
        m_line = 0; m_pix = 0;
      end
      if (s_tlast) begin
        m_pix = 0;
        if (m_line == h - 1) begin fe = 1'b1; m_line = 0; end
        else m_line++;
      end else m_pix++;
    end
    if (fe) begin
      if (m_pend) begin
        m_pend = 1'b0;
        for (int i = 1; i < 9; i++) m_act[i] = m_sh[i];
        m_anim = m_sh[9][0];
        if (m_sh[0] != m_act[0]) begin
          m_act[0] = m_sh[0];
          m_fc = 32'd0; m_run = 1'b0; m_rst_left = RC; m_line = 0; m_pix = 0;
        end else m_fc = m_fc + 32'd1;
      end else begin
        m_fc = m_fc + 32'd1;
        if (m_anim) begin
          m_act[1] = m_act[1] + m_act[7];
          m_act[2] = m_act[2] + m_act[8];
        end
      end
    end
    if (acc) m_pend = 1'b1;
    if (cfg_wr_valid && rdy && cfg_wr_addr <= 4'd9) m_sh[cfg_wr_addr] = cfg_wr_data;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    cfg_wr_valid = 1'b1; cfg_wr_addr = a; cfg_wr_data = d;
    tick();
    cfg_wr_valid = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic beat(input logic u, input logic l);
    int gap;
    gap = int'($urandom_range(0, 2));
    for (int g = 0; g < gap; g++) tick();
    s_tvalid = 1'b1; s_tuser = u; s_tlast = l;
    tick();
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic send_frame(input int h, input int w);
    for (int l = 0; l < h; l++)
      for (int p = 0; p < w; p++) beat(l == 0 && p == 0, p == w - 1);
  endtask

  task automatic test_reset();
    int n;
    resetn = 1'b0;
    repeat (3) tick();
    checks++; if (gen_resetn !== 1'b0) begin errors++; $display("FAIL reset_gen got=%b exp=0", gen_resetn); end
    checks++; if (width_out !== 16'd640) begin errors++; $display("FAIL reset_width got=%0d exp=640", width_out); end
    checks++; if (height_out !== 16'd480) begin errors++; $display("FAIL reset_height got=%0d exp=480", height_out); end
    checks++; if ({cr_out, ci_out, dx_out, dy_out, x0_out, y0_out} !== 192'd0) begin
      errors++; $display("FAIL reset_params got cr=%h ci=%h dx=%h exp=0", cr_out, ci_out, dx_out); end
    checks++; if (cfg_wr_ready !== 1'b0 || commit_pending !== 1'b0 || frame_count !== 32'd0) begin
      errors++; $display("FAIL reset_ctl got rdy=%b pend=%b fc=%0d exp 0/0/0", cfg_wr_ready, commit_pending, frame_count); end
    resetn = 1'b1;
    n = 0;
    while (gen_resetn !== 1'b1 && n < 100) begin tick(); n++; end
    checks++; if (n != RC) begin errors++; $display("FAIL reset_pulse_len got=%0d exp=%0d", n, RC); end
    checks++; if (cfg_wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cfg_wr_ready); end
  endtask

  task automatic test_geometry(input logic [15:0] h, input logic [15:0] w,
                               input int old_h, input int old_w, input logic [31:0] exp_cr);
    int n;
    wr(4'd0, {h, w});
    commit();
    send_frame(old_h, old_w);
    checks++; if (gen_resetn !== 1'b0) begin errors++; $display("FAIL geom_gen_low got=%b exp=0", gen_resetn); end
    n = 0;
    while (gen_resetn !== 1'b1 && n < 100) begin tick(); n++; end
    checks++; if (n != RC) begin errors++; $display("FAIL geom_pulse_len got=%0d exp=%0d", n, RC); end
    checks++; if (width_out !== w || height_out !== h) begin
      errors++; $display("FAIL geom_size got=%0dx%0d exp=%0dx%0d", width_out, height_out, w, h); end
    checks++; if (frame_count !== 32'd0 || commit_pending !== 1'b0) begin
      errors++; $display("FAIL geom_fc got fc=%0d pend=%b exp 0/0", frame_count, commit_pending); end
    checks++; if (cr_out !== exp_cr) begin errors++; $display("FAIL geom_cr_stable got=%h exp=%h", cr_out, exp_cr); end
  endtask

  task automatic test_param_commit();
    wr(4'd1, 32'h0000_1000);
    beat(1'b1, 1'b0); beat(1'b0, 1'b0); beat(1'b0, 1'b0);
    commit();
    checks++; if (commit_pending !== 1'b1 || cr_out !== 32'd0) begin
      errors++; $display("FAIL pc_pending got pend=%b cr=%h exp 1/0", commit_pending, cr_out); end
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b0); beat(1'b0, 1'b0); beat(1'b0, 1'b0);
    checks++; if (cr_out !== 32'd0 || commit_pending !== 1'b1) begin
      errors++; $display("FAIL pc_before_end got cr=%h pend=%b exp 0/1", cr_out, commit_pending); end
    beat(1'b0, 1'b1);
    checks++; if (cr_out !== 32'h0000_1000 || commit_pending !== 1'b0) begin
      errors++; $display("FAIL pc_applied got cr=%h pend=%b exp 1000/0", cr_out, commit_pending); end
    checks++; if (frame_count !== 32'd1) begin errors++; $display("FAIL pc_fc got=%0d exp=1", frame_count); end
  endtask

  task automatic test_anim();
    wr(4'd9, 32'd1); wr(4'd7, 32'd1); wr(4'd8, 32'hFFFF_FFFF); wr(4'd1, 32'h7FFF_FFFF);
    commit();
    send_frame(3, 5);
    checks++; if (cr_out !== 32'h7FFF_FFFF || ci_out !== 32'd0) begin
      errors++; $display("FAIL anim_f1 got cr=%h ci=%h exp 7fffffff/0", cr_out, ci_out); end
    send_frame(3, 5);
    checks++; if (cr_out !== 32'h8000_0000 || ci_out !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL anim_f2 got cr=%h ci=%h exp 80000000/ffffffff", cr_out, ci_out); end
    send_frame(3, 5);
    checks++; if (cr_out !== 32'h8000_0001 || ci_out !== 32'hFFFF_FFFE || frame_count !== 32'd3) begin
      errors++; $display("FAIL anim_f3 got cr=%h ci=%h fc=%0d exp 80000001/fffffffe/3", cr_out, ci_out, frame_count); end
  endtask

  task automatic test_pending();
    logic [31:0] d;
    commit();
    cfg_wr_valid = 1'b1; cfg_wr_addr = 4'd1; cfg_wr_data = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      cfg_commit = (i == 2);
      tick();
      checks++; if (cfg_wr_ready !== 1'b0 || commit_pending !== 1'b1) begin
        errors++; $display("FAIL pend_hold[%0d] got rdy=%b pend=%b exp 0/1", i, cfg_wr_ready, commit_pending); end
    end
    cfg_wr_valid = 1'b0; cfg_commit = 1'b0;
    send_frame(3, 5);
    checks++; if (cr_out !== 32'h7FFF_FFFF || ci_out !== 32'd0 || commit_pending !== 1'b0) begin
      errors++; $display("FAIL pend_apply got cr=%h ci=%h pend=%b exp 7fffffff/0/0", cr_out, ci_out, commit_pending); end
    d = $urandom;
    cfg_wr_valid = 1'b1; cfg_wr_addr = 4'd2; cfg_wr_data = d; cfg_commit = 1'b1;
    tick();
    cfg_wr_valid = 1'b0; cfg_commit = 1'b0;
    checks++; if (commit_pending !== 1'b1 || ci_out !== 32'd0) begin
      errors++; $display("FAIL wrcommit_pend got pend=%b ci=%h exp 1/0", commit_pending, ci_out); end
    send_frame(3, 5);
    checks++; if (ci_out !== d || commit_pending !== 1'b0) begin
      errors++; $display("FAIL wrcommit_apply got ci=%h pend=%b exp %h/0", ci_out, commit_pending, d); end
  endtask

  task automatic test_sync_err();
    logic [31:0] fc0;
    fc0 = frame_count;
    for (int p = 0; p < 5; p++) beat(p == 0, p == 4);
    beat(1'b0, 1'b0); beat(1'b0, 1'b0);
    for (int l = 0; l < 3; l++) begin
      for (int p = 0; p < 5; p++) beat(l == 0 && p == 0, p == 4);
      if (l == 1) begin
        checks++; if (frame_count !== fc0) begin
          errors++; $display("FAIL sync_mid got=%0d exp=%0d", frame_count, fc0); end
      end
    end
    checks++; if (frame_count !== fc0 + 32'd1) begin
      errors++; $display("FAIL sync_clean got=%0d exp=%0d", frame_count, fc0 + 32'd1); end
  endtask

  task automatic test_random();
    logic [31:0] got [0:11];
    logic [31:0] exp [0:11];
    int w;
    for (int c = 0; c < 3000; c++) begin
      resetn = !(c >= 2600 && c < 2602);
      cfg_wr_valid = ($urandom_range(0, 5) == 0);
      cfg_wr_addr = 4'($urandom_range(0, 15));
      cfg_wr_data = $urandom;
      if (cfg_wr_addr == 4'd0) cfg_wr_data = {16'($urandom_range(1, 3)), 16'($urandom_range(1, 4))};
      cfg_commit = ($urandom_range(0, 15) == 0);
      w = int'(m_act[0][15:0]);
      s_tvalid = ($urandom_range(0, 1) == 1);
      s_tlast = (m_pix >= w - 1);
      s_tuser = (m_pix == 0 && m_line == 0) || ($urandom_range(0, 60) == 0);
      tick();
      got[0] = {31'd0, gen_resetn};        exp[0] = {31'd0, m_run};
      got[1] = {16'd0, width_out};         exp[1] = {16'd0, m_act[0][15:0]};
      got[2] = {16'd0, height_out};        exp[2] = {16'd0, m_act[0][31:16]};
      got[3] = cr_out; exp[3] = m_act[1];  got[4] = ci_out; exp[4] = m_act[2];
      got[5] = dx_out; exp[5] = m_act[3];  got[6] = dy_out; exp[6] = m_act[4];
      got[7] = x0_out; exp[7] = m_act[5];  got[8] = y0_out; exp[8] = m_act[6];
      got[9] = {31'd0, commit_pending};    exp[9] = {31'd0, m_pend};
      got[10] = frame_count;               exp[10] = m_fc;
      got[11] = {31'd0, cfg_wr_ready};     exp[11] = {31'd0, m_run && !m_pend};
      for (int k = 0; k < 12; k++) begin
        checks++;
        if (got[k] !== exp[k]) begin
          errors++; $display("FAIL rand_out%0d cycle %0d got=%h exp=%h", k, c, got[k], exp[k]);
        end
      end
    end
    cfg_wr_valid = 1'b0; cfg_commit = 1'b0; s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    resetn = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; cfg_wr_valid = 1'b0; cfg_wr_addr = 4'd0; cfg_wr_data = 32'd0;
    cfg_commit = 1'b0; s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    test_reset();
    test_geometry(16'd2, 16'd4, 480, 1, 32'd0);
    test_param_commit();
    test_geometry(16'd3, 16'd5, 2, 4, 32'h0000_1000);
    test_anim();
    test_pending();
    test_sync_err();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
